// File: rtl/memory_access_unit.sv
// Byte-serial memory port: moves 1/2/4-byte big-endian words between the datapath
// and an 8-bit data memory, issuing one byte access per memory cycle.
module memory_access_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic                  WR,
  input  logic [1:0]            Size,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemCS,
  output logic                  MemWR,
  output logic [7:0]            MemDataOut,
  input  logic [7:0]            MemDataIn
);

  localparam int KW = $clog2(DATA_WIDTH / 8) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [KW-1:0]         n_q, n_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;

  logic                  accept;
  logic                  last_byte;
  logic [KW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] wdata_shift;

  assign accept    = (state_q == S_IDLE) && Start && (Size != 2'b11);
  assign last_byte = (k_q == n_q - KW'(1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_ISSUE;
      S_ISSUE:   if (wr_q) state_d = last_byte ? S_DONE : S_ISSUE;
                 else      state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_byte ? S_DONE : S_ISSUE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request latch, byte counter and read-data assembly
  // NOTE: every comb output starts from a default (hold) value, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    wr_d      = wr_q;
    n_d       = n_q;
    k_d       = k_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        wr_d      = WR;
        base_d    = Address;
        wdata_d   = WrData;
        k_d       = '0;
        rd_data_d = '0;
        case (Size)
          2'b00:   n_d = KW'(1);
          2'b01:   n_d = KW'(2);
          default: n_d = KW'(4);
        endcase
      end
      S_ISSUE:   if (wr_q) k_d = k_q + KW'(1);
      S_CAPTURE: begin
        rd_data_d = {rd_data_q[DATA_WIDTH-9:0], MemDataIn};
        k_d       = k_q + KW'(1);
      end
      default: ;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered
  assign byte_idx    = n_d - KW'(1) - k_d;
  assign wdata_shift = wdata_d >> {byte_idx, 3'b000};

  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_q == S_IDLE) && Start && (Size == 2'b11);
    mem_cs_d   = (state_d == S_ISSUE);
    mem_wr_d   = mem_cs_d && wr_d;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    if (mem_cs_d) begin
      mem_addr_d = base_d + ADDR_WIDTH'(k_d);
      if (wr_d) mem_dout_d = wdata_shift[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      n_q        <= '0;
      k_q        <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      wr_q       <= wr_d;
      n_q        <= n_d;
      k_q        <= k_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mem_cs_q   <= mem_cs_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign RdData     = rd_data_q;
  assign MemAddr    = mem_addr_q;
  assign MemCS      = mem_cs_q;
  assign MemWR      = mem_wr_q;
  assign MemDataOut = mem_dout_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: a 64 KiB byte memory model plus a word-level
// reference (shadow memory, expected byte order, latency) checked on every transfer.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        Start;
  logic        WR;
  logic [1:0]  Size;
  logic [15:0] Address;
  logic [31:0] WrData;
  logic        Busy, Done, Err;
  logic [31:0] RdData;
  logic [15:0] MemAddr;
  logic        MemCS, MemWR;
  logic [7:0]  MemDataOut;
  logic [7:0]  MemDataIn;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         load_mem = 1'b0;

  memory_access_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .Start      (Start),
    .WR         (WR),
    .Size       (Size),
    .Address    (Address),
    .WrData     (WrData),
    .Busy       (Busy),
    .Done       (Done),
    .Err        (Err),
    .RdData     (RdData),
    .MemAddr    (MemAddr),
    .MemCS      (MemCS),
    .MemWR      (MemWR),
    .MemDataOut (MemDataOut),
    .MemDataIn  (MemDataIn)
  );

  always #5 clock = ~clock;

  // Synchronous byte memory: read data appears the cycle after the access
  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
    end else if (MemCS) begin
      if (MemWR) mem[MemAddr] <= MemDataOut;
      else       MemDataIn    <= mem[MemAddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer, checked against the word-level model
  task automatic run_xfer(input logic wr, input logic [1:0] size, input logic [15:0] addr,
                          input logic [31:0] wdata, input bit start_busy);
    int          n;
    int          lat;
    int          exp_lat;
    bit          seen_done;
    logic [31:0] exp_rd;
    logic [15:0] a;
    logic [15:0] got_addr[$];
    logic        got_wr[$];
    logic [7:0]  got_dout[$];
    n       = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_lat = wr ? n + 1 : 2 * n + 1;
    exp_rd  = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      if (wr) ref_mem[a] = wdata[8*(n-1-i) +: 8];
      else    exp_rd     = {exp_rd[23:0], ref_mem[a]};
    end

    @(negedge clock);
    Start = 1'b1; WR = wr; Size = size; Address = addr; WrData = wdata;
    @(posedge clock); #1;
    Start   = 1'b0;
    WR      = 1'($urandom);
    Size    = 2'($urandom_range(0, 3));
    Address = 16'($urandom);
    WrData  = $urandom;

    lat = 0;
    seen_done = 1'b0;
    while (!seen_done && lat < 40) begin
      @(negedge clock);
      lat++;
      check("busy_during", {31'd0, Busy}, 32'd1);
      check("err_during", {31'd0, Err}, 32'd0);
      check("memwr_implies_cs", {31'd0, MemWR & ~MemCS}, 32'd0);
      if (MemCS) begin
        got_addr.push_back(MemAddr);
        got_wr.push_back(MemWR);
        got_dout.push_back(MemDataOut);
      end
      if (Done) seen_done = 1'b1;
      else if (start_busy) Start = 1'($urandom_range(0, 1));
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("access_count", 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check("mem_addr", {16'd0, got_addr[i]}, {16'd0, addr + 16'(i)});
      check("mem_wr", {31'd0, got_wr[i]}, {31'd0, wr});
      if (wr) check("mem_dout", {24'd0, got_dout[i]}, {24'd0, wdata[8*(n-1-i) +: 8]});
    end
    check("rd_data", RdData, exp_rd);

    // Start presented during the DONE cycle must be ignored
    Start = start_busy;
    @(posedge clock); #1;
    Start = 1'b0;
    @(negedge clock);
    check("done_pulse_width", {31'd0, Done}, 32'd0);
    check("busy_after", {31'd0, Busy}, 32'd0);
    check("cs_after", {31'd0, MemCS}, 32'd0);
    check("rd_data_hold", RdData, exp_rd);
    for (int i = 0; i <= n; i++) begin
      a = addr + 16'(i);
      check("mem_contents", {24'd0, mem[a]}, {24'd0, ref_mem[a]});
    end
  endtask

  initial begin
    int cs_seen;
    int done_seen;
    bit hit;
    reset_n = 1'b0;
    Start = 1'b0; WR = 1'b0; Size = 2'b00; Address = '0; WrData = '0;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
    ref_mem[16'h0010] = 8'h12; ref_mem[16'h0011] = 8'h34;
    ref_mem[16'h0012] = 8'h56; ref_mem[16'h0013] = 8'h78;
    ref_mem[16'h0020] = 8'hAB;
    load_mem = 1'b1;
    repeat (2) @(posedge clock);
    #1 load_mem = 1'b0;

    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_cs", {30'd0, MemCS, MemWR}, 32'd0);
    check("rst_rd_data", RdData, 32'd0);
    check("rst_mem_addr", {16'd0, MemAddr}, 32'd0);
    check("rst_mem_dout", {24'd0, MemDataOut}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_xfer(1'b0, 2'b10, 16'h0010, 32'd0, 1'b0);
    check("t1_word", RdData, 32'h12345678);
    run_xfer(1'b0, 2'b00, 16'h0020, 32'd0, 1'b0);
    check("t2_byte", RdData, 32'h000000AB);
    run_xfer(1'b1, 2'b01, 16'h0100, 32'hDEADBEEF, 1'b0);
    check("t3_byte0", {24'd0, mem[16'h0100]}, 32'h000000BE);
    check("t3_byte1", {24'd0, mem[16'h0101]}, 32'h000000EF);
    run_xfer(1'b0, 2'b10, 16'hFFFE, 32'd0, 1'b0);

    // Reserved size: Err pulse only
    @(negedge clock);
    Start = 1'b1; Size = 2'b11; WR = 1'b0; Address = 16'h0040;
    @(posedge clock); #1;
    Start = 1'b0; Size = 2'b00;
    @(negedge clock);
    check("err_pulse", {31'd0, Err}, 32'd1);
    check("err_busy", {31'd0, Busy}, 32'd0);
    check("err_cs", {31'd0, MemCS}, 32'd0);
    @(negedge clock);
    check("err_width", {31'd0, Err}, 32'd0);
    check("err_cs_late", {31'd0, MemCS}, 32'd0);

    run_xfer(1'b0, 2'b10, 16'h0010, 32'd0, 1'b1);
    check("t5_word", RdData, 32'h12345678);

    // Reset during the CAPTURE of byte 2 of a 4-byte read
    @(negedge clock);
    Start = 1'b1; WR = 1'b0; Size = 2'b10; Address = 16'h0200;
    @(posedge clock); #1;
    Start = 1'b0;
    cs_seen = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clock);
      if (MemCS) cs_seen++;
      else if (cs_seen == 3) hit = 1'b1;
    end
    check("abort_reached_capture", {31'd0, hit}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_cs", {31'd0, MemCS}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_rd_data", RdData, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (Done || Busy) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_xfer(1'b0, 2'b10, 16'h0010, 32'd0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] ra;
      ra = (t % 4 == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      run_xfer(1'($urandom), 2'($urandom_range(0, 2)), ra, $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
